// File: rtl/washer_pkg.sv
// Shared types and defaults for the washing-machine plant model.
// Width helper sizes level/counter registers from their maximum value.
package washer_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_WASH,
        M_SPIN,
        M_EXPIRED
    } motor_state_t;

    localparam int DEF_LEVEL_MAX   = 8;
    localparam int DEF_FILL_RATE   = 1;
    localparam int DEF_DRAIN_RATE  = 2;
    localparam int DEF_CYCLE_TICKS = 4;
    localparam int DEF_SPIN_TICKS  = 3;
    localparam int DEF_TICK_DIV    = 1;

    function automatic int calc_lw(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/washer_tick_gen.sv
// Plant prescaler: tick is high one clock in every TICK_DIV; no latency, no backpressure.
// TICK_DIV of 1 ties tick high permanently.
module washer_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    generate
        if (TICK_DIV <= 1) begin : g_every
            logic unused_ports;
            assign unused_ports = clk ^ reset;
            assign tick = 1'b1;
        end else begin : g_div
            localparam int CW = $clog2(TICK_DIV);
            localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    cnt <= '0;
                else if (cnt == LAST)
                    cnt <= '0;
                else
                    cnt <= cnt + CW'(1);
            end

            assign tick = (cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/washer_plant.sv
// Tank/motor plant model answering the washer controller; level and timeouts are registered
// (one clock after the causing edge), inputs are always accepted with no backpressure.
module washer_plant
    import washer_pkg::*;
#(
    parameter int LEVEL_MAX   = DEF_LEVEL_MAX,
    parameter int FILL_RATE   = DEF_FILL_RATE,
    parameter int DRAIN_RATE  = DEF_DRAIN_RATE,
    parameter int CYCLE_TICKS = DEF_CYCLE_TICKS,
    parameter int SPIN_TICKS  = DEF_SPIN_TICKS,
    parameter int TICK_DIV    = DEF_TICK_DIV
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fill_valve_on,
    input  logic                          drain_valve_on,
    input  logic                          motor_on,
    input  logic                          water_wash,
    input  logic                          door_lock,
    output logic                          filled,
    output logic                          drained,
    output logic                          cycle_timeout,
    output logic                          spin_timeout,
    output logic [calc_lw(LEVEL_MAX)-1:0] level,
    output logic                          fault
);

    localparam int LW   = calc_lw(LEVEL_MAX);
    localparam int CMAX = (CYCLE_TICKS > SPIN_TICKS) ? CYCLE_TICKS : SPIN_TICKS;
    localparam int CW   = calc_lw(CMAX);

    localparam logic [LW-1:0] LEVEL_FULL = LW'(LEVEL_MAX);
    localparam logic [LW:0]   FULL_X     = (LW + 1)'(LEVEL_MAX);
    localparam logic [LW:0]   FILL_X     = (LW + 1)'(FILL_RATE);
    localparam logic [LW:0]   DRAIN_X    = (LW + 1)'(DRAIN_RATE);
    localparam logic [CW-1:0] CYC_LIM    = CW'(CYCLE_TICKS);
    localparam logic [CW-1:0] SPIN_LIM   = CW'(SPIN_TICKS);

    logic tick;

    washer_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    logic [LW:0]   level_x, fill_sum, drain_diff;
    logic [LW-1:0] level_nxt;

    // Extra top bit: fill overflow is caught by the compare, drain underflow shows as a borrow.
    always_comb begin
        level_x    = {1'b0, level};
        fill_sum   = level_x + FILL_X;
        drain_diff = level_x - DRAIN_X;
        level_nxt  = level;
        if (tick && fill_valve_on && !drain_valve_on)
            level_nxt = (fill_sum > FULL_X) ? LEVEL_FULL : fill_sum[LW-1:0];
        else if (tick && drain_valve_on && !fill_valve_on)
            level_nxt = drain_diff[LW] ? '0 : drain_diff[LW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
            fault <= 1'b0;
        end else begin
            level <= level_nxt;
            if ((tick && fill_valve_on && drain_valve_on) || (motor_on && !door_lock))
                fault <= 1'b1;
        end
    end

    assign filled  = (level == LEVEL_FULL);
    assign drained = (level == '0);

    motor_state_t  state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          cyc_nxt, spin_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= M_IDLE;
            cnt           <= '0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            cycle_timeout <= cyc_nxt;
            spin_timeout  <= spin_nxt;
        end
    end

    // Expiry wins over a motor drop on the same edge so the pulse is never lost.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cyc_nxt   = 1'b0;
        spin_nxt  = 1'b0;
        cnt_inc   = cnt + CW'(1);
        case (state)
            M_IDLE: begin
                cnt_nxt = '0;
                if (motor_on)
                    state_nxt = water_wash ? M_SPIN : M_WASH;
            end
            M_WASH, M_SPIN: begin
                if (tick)
                    cnt_nxt = cnt_inc;
                if (tick && (cnt_inc == ((state == M_SPIN) ? SPIN_LIM : CYC_LIM))) begin
                    state_nxt = M_EXPIRED;
                    cyc_nxt   = (state == M_WASH);
                    spin_nxt  = (state == M_SPIN);
                end else if (!motor_on) begin
                    state_nxt = M_IDLE;
                end
            end
            M_EXPIRED: begin
                if (!motor_on)
                    state_nxt = M_IDLE;
            end
            default: state_nxt = M_IDLE;
        endcase
    end

endmodule

// File: tb/tb_washer_plant.sv
// Scoreboard bench for washer_plant at default parameters: directed scenarios then random traffic.
module tb_washer_plant;

    localparam int LMAX  = 8;
    localparam int FILLR = 1;
    localparam int DRNR  = 2;
    localparam int CYC   = 4;
    localparam int SPIN  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fill_valve_on = 1'b0;
    logic       drain_valve_on = 1'b0;
    logic       motor_on = 1'b0;
    logic       water_wash = 1'b0;
    logic       door_lock = 1'b1;
    logic       filled, drained, cycle_timeout, spin_timeout, fault;
    logic [3:0] level;

    typedef struct {
        int level;
        bit filled;
        bit drained;
        bit cto;
        bit sto;
        bit fault;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: tank as an integer, motor as "running / which phase / ticks so far / done".
    int m_level;
    bit m_fault, m_run, m_spin, m_done, m_cto, m_sto;
    int m_ticks;

    always #5 clk = ~clk;

    washer_plant dut (
        .clk            (clk),
        .reset          (reset),
        .fill_valve_on  (fill_valve_on),
        .drain_valve_on (drain_valve_on),
        .motor_on       (motor_on),
        .water_wash     (water_wash),
        .door_lock      (door_lock),
        .filled         (filled),
        .drained        (drained),
        .cycle_timeout  (cycle_timeout),
        .spin_timeout   (spin_timeout),
        .level          (level),
        .fault          (fault)
    );

    task automatic model_reset();
        m_level = 0; m_fault = 0; m_run = 0; m_spin = 0;
        m_done = 0; m_ticks = 0; m_cto = 0; m_sto = 0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        if (fill_valve_on && drain_valve_on) m_fault = 1;
        else if (fill_valve_on)  m_level = (m_level + FILLR > LMAX) ? LMAX : m_level + FILLR;
        else if (drain_valve_on) m_level = (m_level - DRNR < 0) ? 0 : m_level - DRNR;
        if (motor_on && !door_lock) m_fault = 1;
        m_cto = 0;
        m_sto = 0;
        if (m_done) begin
            if (!motor_on) m_done = 0;
        end else if (m_run) begin
            m_ticks++;
            if (m_ticks == (m_spin ? SPIN : CYC)) begin
                m_run = 0;
                m_done = 1;
                if (m_spin) m_sto = 1; else m_cto = 1;
            end else if (!motor_on) begin
                m_run = 0;
            end
        end else if (motor_on) begin
            m_run = 1;
            m_spin = water_wash;
            m_ticks = 0;
        end
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.level = m_level;
        e.filled = (m_level == LMAX);
        e.drained = (m_level == 0);
        e.cto = m_cto;
        e.sto = m_sto;
        e.fault = m_fault;
        return e;
    endfunction

    task automatic drive(input logic f, input logic d, input logic m, input logic w, input logic l);
        fill_valve_on = f; drain_valve_on = d; motor_on = m; water_wash = w; door_lock = l;
    endtask

    task automatic step(input logic f, input logic d, input logic m, input logic w,
                        input logic l, input logic r);
        drive(f, d, m, w, l);
        reset = r;
        @(posedge clk);
        model_edge();
        exp_q.push_back(cur_exp());
        @(negedge clk);
    endtask

    // Reset asserted between edges: the cycle's outputs must already be back at reset values.
    task automatic step_async_reset(input logic m, input logic w);
        drive(1'b0, 1'b0, m, w, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        model_edge();
        #2;
        reset = 1'b1;
        model_reset();
        exp_q.push_back(cur_exp());
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("level",         32'(level),         32'(e.level));
                chk("filled",        32'(filled),        32'(e.filled));
                chk("drained",       32'(drained),       32'(e.drained));
                chk("cycle_timeout", 32'(cycle_timeout), 32'(e.cto));
                chk("spin_timeout",  32'(spin_timeout),  32'(e.sto));
                chk("fault",         32'(fault),         32'(e.fault));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(negedge clk);
        repeat (2) step(0, 0, 0, 0, 1, 1);

        // Idle after reset
        repeat (20) step(0, 0, 0, 0, 1, 0);
        // Fill to full, then saturate
        repeat (11) step(1, 0, 0, 0, 1, 0);
        // Drain to empty, then floor
        repeat (5) step(0, 1, 0, 0, 1, 0);
        // Wash run, held long
        repeat (8) step(0, 0, 1, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 1, 0);
        // Spin run, water_wash toggled mid-run
        repeat (2) step(0, 0, 1, 1, 1, 0);
        repeat (5) step(0, 0, 1, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 1, 0);
        // Motor drop one tick early: no pulse
        repeat (3) step(0, 0, 1, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        // Motor drop on the expiry edge: pulse still delivered
        repeat (4) step(0, 0, 1, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        // Both valves at level 3
        repeat (3) step(1, 0, 0, 0, 1, 0);
        repeat (2) step(1, 1, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        // Door unlocked while motor runs
        repeat (2) step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        // Async reset mid-spin at counter 2, with some water in the tank
        repeat (2) step(0, 0, 0, 0, 1, 1);
        repeat (5) step(1, 0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 1, 1, 1, 0);
        step_async_reset(1'b1, 1'b1);
        step(0, 0, 0, 0, 1, 1);
        repeat (6) step(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            logic f, d, m, w, l, r;
            f = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 2) == 0);
            m = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            l = ($urandom_range(0, 15) != 0);
            r = ($urandom_range(0, 59) == 0);
            step(f, d, m, w, l, r);
        end

        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
